spe_omem_port: RTL and testbench

Clocked packet port between one SPE core and the mesh router for all Output Memory (OMEM) traffic. It turns core-side store and residue-request strobes into 33-bit OMEM packets and returns OMEM residue responses to the core. It also decodes timestep-done broadcasts into a pulse and a timestep counter. One instance sits beside each of SPE 0..4.

---
 rtl/spe_omem_port.sv | 100 ++++++++++
 tb/tb_spe_omem_port.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spe_omem_port.sv
// spe_omem_port: OMEM packet port between one SPE core and the mesh router
// Turns core stores and residue requests into 33-bit packets
// ({dest[3:0], opcode[3:0], data[24:0]}), returns residue responses to the core,
// and decodes timestep-done broadcasts into ts_done/ts_cur.
// Ports: clk/rst_n (sync, active-low); st_* core store handshake; rq_* core residue
// request; resid_valid/resid_data residue return; pkt_out_* router-bound packets;
// pkt_in_* router-side packets; ts_done/ts_cur timestep; store_cnt stores this
// timestep; err_stray sticky dropped-packet flag.
// Optional: RESP_TIMEOUT_EN enables the response watchdog (TIMEOUT cycles).
module spe_omem_port #(
  parameter int SPE_IDX = 0,
  parameter int OMEM_ID = 12,
  parameter int SUM_WIDTH = 13,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [SUM_WIDTH-1:0] st_potential,
  input  logic                 st_spike,
  input  logic                 rq_valid,
  output logic                 rq_ready,
  output logic                 resid_valid,
  output logic [SUM_WIDTH-1:0] resid_data,
  output logic                 pkt_out_valid,
  input  logic                 pkt_out_ready,
  output logic [32:0]          pkt_out_data,
  input  logic                 pkt_in_valid,
  output logic                 pkt_in_ready,
  input  logic [32:0]          pkt_in_data,
  output logic                 ts_done,
  output logic [1:0]           ts_cur,
  output logic [6:0]           store_cnt,
  output logic                 err_stray
);
  localparam logic [1:0] IDLE = 2'd0, SEND_ST = 2'd1, SEND_RQ = 2'd2, WAIT_RESP = 2'd3;
  logic [1:0] state, nxt;
  logic st_acc, rq_acc, out_hs, st_done, in_hs, in_mine, in_ts, in_resp, stray, timeout;
  logic [32:0] st_pkt, rq_pkt;
  logic unused_bits;
  assign st_acc = st_valid && st_ready;
  assign rq_acc = rq_valid && rq_ready && !st_valid;
  assign out_hs = pkt_out_valid && pkt_out_ready;
  assign st_done = out_hs && state == SEND_ST;
  assign in_hs = pkt_in_valid && pkt_in_ready;
  assign in_mine = pkt_in_data[32:29] == 4'(SPE_IDX);
  assign in_ts = in_hs && in_mine && pkt_in_data[28:25] == 4'hf;
  assign in_resp = in_hs && in_mine && pkt_in_data[28:25] != 4'hf && state == WAIT_RESP;
  assign stray = in_hs && !in_ts && !in_resp;
  assign st_pkt = {4'(OMEM_ID), 4'(2 * SPE_IDX), {(24 - SUM_WIDTH){1'b0}}, st_potential, st_spike};
  assign rq_pkt = {4'(OMEM_ID), 4'(2 * SPE_IDX + 1), 25'd0};
  assign unused_bits = ^pkt_in_data[24:SUM_WIDTH];
`ifdef RESP_TIMEOUT_EN
  logic [15:0] tcnt;
  // tcnt is 0 in the first WAIT_RESP cycle, so the watchdog fires at the end of cycle TIMEOUT+1
  assign timeout = state == WAIT_RESP && !in_resp && tcnt == 16'(TIMEOUT);
  always_ff @(posedge clk) tcnt <= (!rst_n || state != WAIT_RESP) ? 16'd0 : tcnt + 16'd1;
`else
  logic [31:0] unused_to;
  assign unused_to = TIMEOUT;
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = state == IDLE    ? (st_acc ? SEND_ST : rq_acc ? SEND_RQ : IDLE) :
          state == SEND_ST ? (out_hs ? IDLE : SEND_ST) :
          state == SEND_RQ ? (out_hs ? WAIT_RESP : SEND_RQ) :
          (in_resp || timeout) ? IDLE : WAIT_RESP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      st_ready <= 1'b0;
      rq_ready <= 1'b0;
      pkt_out_valid <= 1'b0;
      pkt_out_data <= '0;
      pkt_in_ready <= 1'b0;
      resid_valid <= 1'b0;
      resid_data <= '0;
      ts_done <= 1'b0;
      ts_cur <= 2'd1;
      store_cnt <= '0;
      err_stray <= 1'b0;
    end else begin
      state <= nxt;
      st_ready <= nxt == IDLE;
      rq_ready <= nxt == IDLE;
      pkt_out_valid <= nxt == SEND_ST || nxt == SEND_RQ;
      pkt_out_data <= st_acc ? st_pkt : rq_acc ? rq_pkt : pkt_out_data;
      pkt_in_ready <= 1'b1;
      resid_valid <= in_resp || timeout;
      resid_data <= in_resp ? pkt_in_data[SUM_WIDTH-1:0] : timeout ? '0 : resid_data;
      ts_done <= in_ts;
      ts_cur <= in_ts ? 2'd2 : ts_cur;
      // a store finishing alongside timestep-done belongs to the new timestep
      store_cnt <= in_ts ? {6'd0, st_done} : (st_done && store_cnt != 7'd127) ? store_cnt + 7'd1 : store_cnt;
      err_stray <= err_stray || stray || timeout;
    end
  end
endmodule

// File: tb/tb_spe_omem_port.sv
// tb_spe_omem_port: self-checking bench for spe_omem_port against a transaction-level model
module tb_spe_omem_port;
  localparam int IDX = 3, OM = 12, SW = 13, TMO = 10;
  logic clk = 0, rst_n = 0;
  logic st_valid = 0, st_spike = 0, rq_valid = 0, pkt_out_ready = 0, pkt_in_valid = 0;
  logic [SW-1:0] st_potential = '0;
  logic [32:0] pkt_in_data = '0;
  logic st_ready, rq_ready, resid_valid, pkt_out_valid, pkt_in_ready, ts_done, err_stray;
  logic [SW-1:0] resid_data;
  logic [32:0] pkt_out_data;
  logic [1:0] ts_cur;
  logic [6:0] store_cnt;
  int n_ast = 0, n_fail = 0;
  logic [32:0] q[$];
  logic m_wait = 0, m_err = 0, e_rv = 0, e_td = 0;
  int m_wcyc = 0;
  logic [6:0] m_cnt = 0;
  logic [1:0] m_ts = 1;
  logic [SW-1:0] m_rd = 0;
  spe_omem_port #(.SPE_IDX(IDX), .OMEM_ID(OM), .SUM_WIDTH(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_potential(st_potential), .st_spike(st_spike), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .resid_valid(resid_valid), .resid_data(resid_data), .pkt_out_valid(pkt_out_valid),
    .pkt_out_ready(pkt_out_ready), .pkt_out_data(pkt_out_data), .pkt_in_valid(pkt_in_valid),
    .pkt_in_ready(pkt_in_ready), .pkt_in_data(pkt_in_data), .ts_done(ts_done), .ts_cur(ts_cur),
    .store_cnt(store_cnt), .err_stray(err_stray)
  );
  always #5 clk = ~clk;
  function automatic logic [32:0] st_pkt(int pot, bit sp);
    return (33'(OM) << 29) + (33'(2 * IDX) << 25) + 33'(pot) * 33'd2 + 33'(sp);
  endfunction
  function automatic logic [32:0] rq_pkt();
    return (33'(OM) << 29) + (33'(2 * IDX + 1) << 25);
  endfunction
  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    n_ast++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    logic r, st_acc, rq_acc, out_hs, in_hs, mine, ts, resp, tmo, st_done, rdy;
    logic [32:0] p;
    r = rst_n;
    st_acc = r && st_valid && st_ready;
    rq_acc = r && rq_valid && rq_ready && !st_valid;
    out_hs = r && pkt_out_valid && pkt_out_ready && q.size() != 0;
    in_hs = r && pkt_in_valid && pkt_in_ready;
    mine = pkt_in_data[32:29] == 4'(IDX);
    ts = in_hs && mine && pkt_in_data[28:25] == 4'hf;
    resp = in_hs && mine && !ts && m_wait;
    tmo = 0;
    st_done = 0;
`ifdef RESP_TIMEOUT_EN
    if (m_wait && !resp) begin
      m_wcyc++;
      tmo = m_wcyc == TMO + 1;
    end
`endif
    if (resp || tmo) m_wait = 0;
    e_rv = resp || tmo;
    if (resp) m_rd = pkt_in_data[SW-1:0];
    else if (tmo) m_rd = '0;
    if ((in_hs && !ts && !resp) || tmo) m_err = 1;
    e_td = ts;
    if (ts) m_ts = 2;
    if (out_hs) begin
      p = q.pop_front();
      st_done = !p[25];
      if (p[25]) begin
        m_wait = 1;
        m_wcyc = 0;
      end
    end
    if (ts) m_cnt = {6'd0, st_done};
    else if (st_done && m_cnt < 127) m_cnt++;
    if (st_acc) q.push_back(st_pkt(int'(st_potential), st_spike));
    else if (rq_acc) q.push_back(rq_pkt());
    if (!r) begin
      q.delete();
      m_wait = 0; m_err = 0; m_cnt = 0; m_ts = 1; m_rd = '0; e_rv = 0; e_td = 0;
    end
    @(posedge clk);
    #1;
    rdy = r && q.size() == 0 && !m_wait;
    chk("st_ready", st_ready, rdy);
    chk("rq_ready", rq_ready, rdy);
    chk("pkt_in_ready", pkt_in_ready, r);
    chk("pkt_out_valid", pkt_out_valid, q.size() != 0);
    if (q.size() != 0) chk("pkt_out_data", pkt_out_data, q[0]);
    else if (!r) chk("pkt_out_data_rst", pkt_out_data, 0);
    chk("resid_valid", resid_valid, e_rv);
    chk("resid_data", resid_data, m_rd);
    chk("ts_done", ts_done, e_td);
    chk("ts_cur", ts_cur, m_ts);
    chk("store_cnt", store_cnt, m_cnt);
    chk("err_stray", err_stray, m_err);
  endtask
  task automatic send_in(logic [32:0] p);
    pkt_in_valid = 1;
    pkt_in_data = p;
    tick();
    pkt_in_valid = 0;
  endtask
  task automatic store(int pot, bit sp);
    st_valid = 1;
    st_potential = SW'(pot);
    st_spike = sp;
    tick();
    st_valid = 0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_ts_cur", ts_cur, 1);
    rst_n = 1;
    tick();
    chk("ready_after_rst", st_ready, 1);
    // basic store
    pkt_out_ready = 1;
    store(300, 1);
    chk("store_pkt", pkt_out_data, {4'd12, 4'd6, 25'd601});
    tick();
    tick();
    chk("store_cnt_1", store_cnt, 1);
    // backpressure for 5 cycles
    pkt_out_ready = 0;
    store(4095, 0);
    repeat (5) tick();
    pkt_out_ready = 1;
    tick();
    tick();
    chk("store_cnt_2", store_cnt, 2);
    // request, timestep-done while waiting, then response
    pkt_out_ready = 0;
    rq_valid = 1;
    tick();
    rq_valid = 0;
    chk("rq_pkt", pkt_out_data, {4'd12, 4'd7, 25'd0});
    pkt_out_ready = 1;
    tick();
    send_in({4'(IDX), 4'd15, 25'd0});
    chk("ts_pulse", ts_done, 1);
    chk("ts_cur_2", ts_cur, 2);
    chk("ts_clear", store_cnt, 0);
    send_in({4'(IDX), 4'(IDX), 25'd77});
    chk("resid_77", resid_data, 77);
    chk("resid_pulse", resid_valid, 1);
    tick();
    // stray packets
    send_in({4'd1, 4'd0, 25'd5});
    chk("stray_dest", err_stray, 1);
    send_in({4'(IDX), 4'(IDX), 25'd9});
    chk("stray_idle_no_resid", resid_valid, 0);
    // store wins over request
    pkt_out_ready = 0;
    st_valid = 1;
    rq_valid = 1;
    tick();
    st_valid = 0;
    rq_valid = 0;
    chk("store_wins", pkt_out_data[28:25], 6);
    // store completing with timestep-done counts after the clear
    pkt_out_ready = 1;
    send_in({4'(IDX), 4'd15, 25'd0});
    chk("store_with_ts", store_cnt, 1);
    // saturation
    for (int i = 0; i < 130; i++) begin
      store(i, i[0]);
      tick();
    end
    chk("store_sat", store_cnt, 127);
    // reset mid-transfer
    pkt_out_ready = 0;
    store(55, 1);
    tick();
    rst_n = 0;
    tick();
    chk("abort_valid", pkt_out_valid, 0);
    rst_n = 1;
    tick();
`ifdef RESP_TIMEOUT_EN
    pkt_out_ready = 1;
    rq_valid = 1;
    tick();
    rq_valid = 0;
    tick();
    repeat (10) tick();
    chk("to_not_yet", resid_valid, 0);
    tick();
    chk("to_pulse", resid_valid, 1);
    chk("to_data", resid_data, 0);
    chk("to_err", err_stray, 1);
    chk("to_rq_ready", rq_ready, 1);
`endif
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      st_valid = $urandom % 3 == 0;
      st_potential = SW'($urandom);
      st_spike = 1'($urandom);
      rq_valid = $urandom % 5 == 0;
      pkt_out_ready = $urandom % 4 != 0;
      pkt_in_valid = 0;
      r = int'($urandom % 16);
      if (m_wait && r < 4) begin
        pkt_in_valid = 1;
        pkt_in_data = {4'(IDX), 4'(r), 25'($urandom)};
      end else if (r == 5) begin
        pkt_in_valid = 1;
        pkt_in_data = {4'(IDX), 4'd15, 25'd0};
      end else if (r == 6) begin
        pkt_in_valid = 1;
        pkt_in_data = 33'({$urandom, $urandom});
      end
      tick();
    end
    st_valid = 0;
    rq_valid = 0;
    pkt_in_valid = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_ast, n_fail);
    $finish;
  end
endmodule
